// File: rtl/combo_entry_controller.sv
// Keypad combination-lock sequencer: collects digit entries, checks them against a volatile
// stored code, counts failed attempts, enforces a timed lockout and allows re-programming.
module combo_entry_controller #(
  parameter int unsigned                CODE_LEN       = 4,
  parameter int unsigned                MAX_TRIES      = 3,
  parameter int unsigned                LOCKOUT_CYCLES = 1000000,
  parameter int unsigned                TIMEOUT_CYCLES = 500000,
  parameter logic [CODE_LEN*4-1:0]      DEFAULT_CODE   = 16'h1234
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic       lock,
  output logic       green,
  output logic       blue,
  output logic       locked_out,
  output logic [3:0] tries_left
);

  localparam int unsigned CW   = CODE_LEN * 4;
  localparam int unsigned CNTW = $clog2(CODE_LEN + 1);
  localparam int unsigned TMAX = (LOCKOUT_CYCLES > TIMEOUT_CYCLES) ? LOCKOUT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam logic [3:0] KEY_PROG  = 4'hC;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    PROGRAM = 3'd4,
    LOCKOUT = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   buffer_q, buffer_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [CW-1:0]   code_q, code_d;
  logic [3:0]      tries_q, tries_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic            accept;
  logic            is_digit;
  logic            is_clear;
  logic            is_enter;
  logic            is_prog;
  logic            full;
  logic [CW-1:0]   buf_shift;
  logic [3:0]      tries_dec;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      buffer_q <= '0;
      count_q  <= '0;
      code_q   <= DEFAULT_CODE;
      tries_q  <= 4'(MAX_TRIES);
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      buffer_q <= buffer_d;
      count_q  <= count_d;
      code_q   <= code_d;
      tries_q  <= tries_d;
      timer_q  <= timer_d;
    end
  end

  // Moore outputs decoded from the registered state only.
  always_comb begin
    key_ready  = 1'b0;
    lock       = 1'b1;
    green      = 1'b0;
    blue       = 1'b0;
    locked_out = 1'b0;
    case (state_q)
      IDLE:    key_ready = 1'b1;
      ENTRY: begin
        key_ready = 1'b1;
        blue      = 1'b1;
      end
      OPEN: begin
        key_ready = 1'b1;
        lock      = 1'b0;
        green     = 1'b1;
      end
      PROGRAM: begin
        key_ready = 1'b1;
        lock      = 1'b0;
        green     = 1'b1;
        blue      = 1'b1;
      end
      LOCKOUT: locked_out = 1'b1;
      default: ;
    endcase
  end

  assign tries_left = tries_q;

  always_comb begin
    accept    = key_valid & key_ready;
    is_digit  = (key_code <= 4'd9);
    is_clear  = (key_code == KEY_CLEAR);
    is_enter  = (key_code == KEY_ENTER);
    is_prog   = (key_code == KEY_PROG);
    full      = (count_q == CNTW'(CODE_LEN));
    buf_shift = CW'({buffer_q, key_code});
    tries_dec = (tries_q != 4'd0) ? (tries_q - 4'd1) : 4'd0;
  end

  always_comb begin
    state_d  = state_q;
    buffer_d = buffer_q;
    count_d  = count_q;
    code_d   = code_q;
    tries_d  = tries_q;
    timer_d  = timer_q;

    case (state_q)
      IDLE: begin
        if (accept && is_digit) begin
          buffer_d = CW'(key_code);
          count_d  = CNTW'(1);
          timer_d  = TW'(TIMEOUT_CYCLES - 1);
          state_d  = ENTRY;
        end
      end

      ENTRY: begin
        // An accepted key always wins over timer expiry in the same cycle.
        if (accept) begin
          timer_d = TW'(TIMEOUT_CYCLES - 1);
          if (is_digit) begin
            if (!full) begin
              buffer_d = buf_shift;
              count_d  = count_q + CNTW'(1);
            end
          end else if (is_clear) begin
            buffer_d = '0;
            count_d  = '0;
          end else if (is_enter) begin
            state_d = CHECK;
          end
        end else if (timer_q == '0) begin
          buffer_d = '0;
          count_d  = '0;
          state_d  = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      CHECK: begin
        buffer_d = '0;
        count_d  = '0;
        if (full && (buffer_q == code_q)) begin
          tries_d = 4'(MAX_TRIES);
          state_d = OPEN;
        end else begin
          tries_d = tries_dec;
          if (tries_dec == 4'd0) begin
            timer_d = TW'(LOCKOUT_CYCLES - 1);
            state_d = LOCKOUT;
          end else begin
            state_d = IDLE;
          end
        end
      end

      LOCKOUT: begin
        if (timer_q == '0) begin
          tries_d = 4'(MAX_TRIES);
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      OPEN: begin
        if (accept) begin
          if (is_enter) begin
            state_d = IDLE;
          end else if (is_prog) begin
            buffer_d = '0;
            count_d  = '0;
            state_d  = PROGRAM;
          end
        end
      end

      PROGRAM: begin
        if (accept) begin
          if (is_digit) begin
            if (!full) begin
              buffer_d = buf_shift;
              count_d  = count_q + CNTW'(1);
            end
          end else if (is_clear) begin
            buffer_d = '0;
            count_d  = '0;
          end else if (is_enter) begin
            // A short entry leaves the stored combination untouched.
            if (full) begin
              code_d = buffer_q;
            end
            buffer_d = '0;
            count_d  = '0;
            state_d  = OPEN;
          end
        end
      end

      default: begin
        buffer_d = '0;
        count_d  = '0;
        state_d  = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_combo_entry_controller.sv
// Directed test of combo_entry_controller: open/relock, lockout, short entry, programming,
// timeout and reset behaviour, checked with immediate assertions on the output bundle.
module tb_combo_entry_controller;

  logic       clk;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       lock;
  logic       green;
  logic       blue;
  logic       locked_out;
  logic [3:0] tries_left;

  int n_assert = 0;
  int n_fail   = 0;

  localparam int S_IDLE    = 0;
  localparam int S_ENTRY   = 1;
  localparam int S_CHECK   = 2;
  localparam int S_OPEN    = 3;
  localparam int S_PROGRAM = 4;
  localparam int S_LOCKOUT = 5;

  combo_entry_controller #(
    .CODE_LEN       (4),
    .MAX_TRIES      (3),
    .LOCKOUT_CYCLES (16),
    .TIMEOUT_CYCLES (32),
    .DEFAULT_CODE   (16'h1234)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .lock       (lock),
    .green      (green),
    .blue       (blue),
    .locked_out (locked_out),
    .tries_left (tries_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {key_ready, lock, green, blue, locked_out, tries_left} for a state.
  function automatic logic [8:0] st(input int s, input int t);
    logic [4:0] f;
    case (s)
      S_IDLE:    f = 5'b11000;
      S_ENTRY:   f = 5'b11010;
      S_CHECK:   f = 5'b01000;
      S_OPEN:    f = 5'b10100;
      S_PROGRAM: f = 5'b10110;
      default:   f = 5'b01001;
    endcase
    return {f, 4'(t)};
  endfunction

  task automatic check(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {key_ready, lock, green, blue, locked_out, tries_left};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic code4(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
  endtask

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    step();
    step();
    check("reset", st(S_IDLE, 3));
    rst_n = 1'b1;

    // 1: default code opens, enter relocks
    press(4'h1);
    check("t1_entry", st(S_ENTRY, 3));
    press(4'h2); press(4'h3); press(4'h4);
    press(4'hB);
    check("t1_check", st(S_CHECK, 3));
    step();
    check("t1_open", st(S_OPEN, 3));
    press(4'hB);
    check("t1_relock", st(S_IDLE, 3));

    // 2: three failures -> 16-cycle lockout, keys refused
    code4(16'h9999); press(4'hB); step();
    check("t2_try1", st(S_IDLE, 2));
    code4(16'h9999); press(4'hB); step();
    check("t2_try2", st(S_IDLE, 1));
    code4(16'h9999); press(4'hB);
    check("t2_check3", st(S_CHECK, 1));
    step();
    check("t2_lockout_first", st(S_LOCKOUT, 0));
    for (int i = 1; i <= 15; i++) begin
      if (i == 5) begin
        press(4'h1);
        check("t2_lockout_key", st(S_LOCKOUT, 0));
      end else begin
        step();
      end
    end
    check("t2_lockout_last", st(S_LOCKOUT, 0));
    step();
    check("t2_lockout_exit", st(S_IDLE, 3));

    // 3: short entry fails; extra digit ignored after a full entry
    press(4'h1); press(4'h2); press(4'hB); step();
    check("t3_short", st(S_IDLE, 2));
    code4(16'h1234); press(4'h5); press(4'hB); step();
    check("t3_overflow_open", st(S_OPEN, 3));

    // 4: program 5678, old code rejected, new accepted, reset restores default
    press(4'hC);
    check("t4_program", st(S_PROGRAM, 3));
    code4(16'h5678); press(4'hB);
    check("t4_prog_done", st(S_OPEN, 3));
    press(4'hB);
    check("t4_relock", st(S_IDLE, 3));
    code4(16'h1234); press(4'hB); step();
    check("t4_old_code", st(S_IDLE, 2));
    code4(16'h5678); press(4'hB); step();
    check("t4_new_code", st(S_OPEN, 3));
    press(4'hB);
    @(negedge clk);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t4_rst", st(S_IDLE, 3));
    code4(16'h1234); press(4'hB); step();
    check("t4_default_back", st(S_OPEN, 3));
    press(4'hB);

    // 5: inactivity timeout, and key in expiry cycle reloads the timer
    press(4'h1);
    repeat (31) step();
    check("t5_before_timeout", st(S_ENTRY, 3));
    step();
    check("t5_timeout", st(S_IDLE, 3));
    press(4'h1);
    repeat (31) step();
    press(4'h2);
    check("t5_expiry_key", st(S_ENTRY, 3));
    repeat (31) step();
    check("t5_reloaded", st(S_ENTRY, 3));
    step();
    check("t5_timeout2", st(S_IDLE, 3));
    press(4'hE);
    check("t5_ignored_e", st(S_IDLE, 3));

    // 6: clear mid-entry, key held during CHECK, reset in ENTRY
    press(4'h1); press(4'h2); press(4'hA);
    check("t6_clear", st(S_ENTRY, 3));
    code4(16'h1234);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'hB;
    step();
    check("t6_check_held", st(S_CHECK, 3));
    step();
    key_valid = 1'b0;
    check("t6_open", st(S_OPEN, 3));
    press(4'hB);
    press(4'h9); press(4'hB); step();
    check("t6_fail", st(S_IDLE, 2));
    press(4'h1);
    check("t6_entry", st(S_ENTRY, 2));
    @(negedge clk);
    rst_n = 1'b0;
    step();
    check("t6_rst_entry", st(S_IDLE, 3));
    rst_n = 1'b1;
    press(4'hB);
    check("t6_idle_enter", st(S_IDLE, 3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
